// File: rtl/unary_root_sched_pkg.sv
// Shared definitions for the unary square-root job scheduler.
//   sched_state_e       : scheduler FSM states
//   DEFAULT_INPUT_WIDTH : default unary stream length in bits
//   TIMEOUT_MULT        : watchdog limit as a multiple of the stream length
package unary_root_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        RESP   = 3'd4
    } sched_state_e;

    localparam int DEFAULT_INPUT_WIDTH = 32;
    localparam int TIMEOUT_MULT        = 4;

endpackage

// File: rtl/unary_root_scheduler_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after the pointer position, wrapping around.
//   req    : request vector
//   ptr    : highest-priority index
//   en     : grant enable (no grant when low)
//   gnt    : one-hot grant
//   gnt_id : binary index of the grant (0 when none)
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id
);

    logic found_s;
    int   idx_s;

    // Scan from the pointer upward and keep the first hit.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s = (int'(ptr) + i) % NUM_REQ;
            if (en && !found_s && req[idx_s]) begin
                found_s    = 1'b1;
                gnt[idx_s] = 1'b1;
                gnt_id     = ID_W'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/unary_root_scheduler.sv
// Arbitrating job controller for one shared unary square-root datapath.
// Jobs (binary ones-counts) are taken round-robin, converted to an evenly
// spread unary stream, fed to the datapath, and the datapath's output stream
// is counted and returned tagged with the requester ID.
//   clk, reset                 : clock, asynchronous active-low reset
//   req_valid/req_value        : per-requester job requests
//   req_ready                  : one-hot accept strobe (combinational, IDLE only)
//   rsp_valid/rsp_ready        : result handshake
//   rsp_id/rsp_value/rsp_error : result owner, ones-count, watchdog abort
//   dp_reset_n/dp_a/dp_ready   : datapath reset, input bit and its strobe
//   dp_y/dp_valid              : datapath output bit and its strobe
// Optional feature: define UNARY_ROOT_SCHED_TIMEOUT_EN to enable a watchdog
// that aborts a job after TIMEOUT_CYCLES cycles in STREAM+DRAIN.
module unary_root_scheduler
    import unary_root_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int INPUT_WIDTH    = DEFAULT_INPUT_WIDTH,
    parameter int COUNT_WIDTH    = $clog2(INPUT_WIDTH + 1),
    parameter int ID_WIDTH       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int TIMEOUT_CYCLES = TIMEOUT_MULT * INPUT_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0][COUNT_WIDTH-1:0] req_value,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [ID_WIDTH-1:0]               rsp_id,
    output logic [COUNT_WIDTH-1:0]            rsp_value,
    output logic                              rsp_error,
    output logic                              dp_reset_n,
    output logic                              dp_a,
    output logic                              dp_ready,
    input  logic                              dp_y,
    input  logic                              dp_valid
);

    localparam int ARB_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [COUNT_WIDTH-1:0] FULL_CNT = COUNT_WIDTH'(INPUT_WIDTH);
    localparam logic [COUNT_WIDTH:0]   FULL_SUM = (COUNT_WIDTH + 1)'(INPUT_WIDTH);
    localparam logic [ARB_W-1:0]       LAST_ID  = ARB_W'(NUM_REQ - 1);

    sched_state_e            state_r;
    logic                    run_r;
    logic [ARB_W-1:0]        ptr_r;
    logic [COUNT_WIDTH-1:0]  value_r;
    logic [COUNT_WIDTH:0]    acc_r;
    logic [COUNT_WIDTH-1:0]  in_cnt_r;
    logic [COUNT_WIDTH-1:0]  out_cnt_r;
    logic [COUNT_WIDTH-1:0]  ones_r;
    logic                    rsp_valid_r;
    logic [ID_WIDTH-1:0]     rsp_id_r;
    logic [COUNT_WIDTH-1:0]  rsp_value_r;
    logic                    dp_reset_n_r;
    logic                    dp_a_r;
    logic                    dp_ready_r;

    logic                    arb_en_s;
    logic [NUM_REQ-1:0]      gnt_s;
    logic [ARB_W-1:0]        gnt_id_s;
    logic [COUNT_WIDTH-1:0]  sat_value_s;
    logic [COUNT_WIDTH:0]    acc_base_s;
    logic [COUNT_WIDTH:0]    sum_s;
    logic [COUNT_WIDTH:0]    acc_next_s;
    logic                    bit_s;
    logic                    collect_s;
    logic [COUNT_WIDTH-1:0]  ones_next_s;
    logic                    out_done_s;
    logic                    timeout_s;

    // run_r holds off grants until the first clock after reset release, so
    // req_ready is low throughout reset and dp_reset_n rises on that clock.
    assign arb_en_s = (state_r == IDLE) && run_r;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr_r),
        .en     (arb_en_s),
        .gnt    (gnt_s),
        .gnt_id (gnt_id_s)
    );

    assign req_ready  = gnt_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_value  = rsp_value_r;
    assign dp_reset_n = dp_reset_n_r;
    assign dp_a       = dp_a_r;
    assign dp_ready   = dp_ready_r;

    // Unary encoder step, input saturation and output-collection terms.
    always_comb begin
        // The first stream bit is computed while in CLEAR from a zero accumulator.
        acc_base_s = (state_r == CLEAR) ? '0 : acc_r;
        sum_s      = acc_base_s + {1'b0, value_r};
        if (sum_s >= FULL_SUM) begin
            bit_s      = 1'b1;
            acc_next_s = sum_s - FULL_SUM;
        end else begin
            bit_s      = 1'b0;
            acc_next_s = sum_s;
        end
        if (req_value[gnt_id_s] > FULL_CNT) begin
            sat_value_s = FULL_CNT;
        end else begin
            sat_value_s = req_value[gnt_id_s];
        end
        collect_s   = dp_valid && ((state_r == STREAM) || (state_r == DRAIN));
        ones_next_s = ones_r + {{(COUNT_WIDTH - 1){1'b0}}, dp_y};
        out_done_s  = collect_s && (out_cnt_r == (FULL_CNT - COUNT_WIDTH'(1)));
    end

`ifdef UNARY_ROOT_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_r;
    logic            rsp_error_r;

    assign timeout_s = ((state_r == STREAM) || (state_r == DRAIN)) && (wd_cnt_r == WD_LAST);
    assign rsp_error = rsp_error_r;

    // Watchdog: cycles spent in STREAM+DRAIN for the current job.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_r <= '0;
        end else if (state_r == CLEAR) begin
            wd_cnt_r <= '0;
        end else if ((state_r == STREAM) || (state_r == DRAIN)) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    // Abort flag: set on a watchdog exit (a normal completion wins), cleared leaving RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_error_r <= 1'b0;
        end else if (timeout_s && !out_done_s) begin
            rsp_error_r <= 1'b1;
        end else if ((state_r == RESP) && rsp_ready) begin
            rsp_error_r <= 1'b0;
        end else begin
            rsp_error_r <= rsp_error_r;
        end
    end
`else
    logic unused_cfg_s;

    assign timeout_s    = 1'b0;
    assign rsp_error    = 1'b0;
    assign unused_cfg_s = (TIMEOUT_CYCLES > 0);
`endif

    // Scheduler FSM with all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            run_r        <= 1'b0;
            ptr_r        <= '0;
            value_r      <= '0;
            acc_r        <= '0;
            in_cnt_r     <= '0;
            out_cnt_r    <= '0;
            ones_r       <= '0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= '0;
            rsp_value_r  <= '0;
            dp_reset_n_r <= 1'b0;
            dp_a_r       <= 1'b0;
            dp_ready_r   <= 1'b0;
        end else begin
            run_r <= 1'b1;
            case (state_r)
                IDLE: begin
                    if (|gnt_s) begin
                        value_r      <= sat_value_s;
                        rsp_id_r     <= ID_WIDTH'(gnt_id_s);
                        ptr_r        <= (gnt_id_s == LAST_ID) ? '0 : gnt_id_s + ARB_W'(1);
                        dp_reset_n_r <= 1'b0;
                        state_r      <= CLEAR;
                    end else begin
                        dp_reset_n_r <= 1'b1;
                    end
                end
                CLEAR: begin
                    dp_reset_n_r <= 1'b1;
                    acc_r        <= acc_next_s;
                    dp_a_r       <= bit_s;
                    dp_ready_r   <= 1'b1;
                    in_cnt_r     <= COUNT_WIDTH'(1);
                    out_cnt_r    <= '0;
                    ones_r       <= '0;
                    state_r      <= STREAM;
                end
                STREAM, DRAIN: begin
                    if (collect_s) begin
                        out_cnt_r <= out_cnt_r + COUNT_WIDTH'(1);
                        ones_r    <= ones_next_s;
                    end
                    // A full output count ends the job even mid-STREAM.
                    if (out_done_s || timeout_s) begin
                        rsp_valid_r <= 1'b1;
                        rsp_value_r <= collect_s ? ones_next_s : ones_r;
                        dp_ready_r  <= 1'b0;
                        dp_a_r      <= 1'b0;
                        state_r     <= RESP;
                    end else if ((state_r == STREAM) && (in_cnt_r == FULL_CNT)) begin
                        dp_ready_r <= 1'b0;
                        dp_a_r     <= 1'b0;
                        state_r    <= DRAIN;
                    end else if (state_r == STREAM) begin
                        dp_a_r   <= bit_s;
                        acc_r    <= acc_next_s;
                        in_cnt_r <= in_cnt_r + COUNT_WIDTH'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unary_root_scheduler.sv
`timescale 1ns/1ps
module tb_unary_root_scheduler;

    localparam int W  = 32;
    localparam int NR = 4;
    localparam int CW = 6;
    localparam int IW = 2;
    localparam int M_ECHO  = 0;
    localparam int M_SQRT  = 1;
    localparam int M_STUCK = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NR-1:0]          req_valid;
    logic [NR-1:0][CW-1:0]  req_value;
    logic [NR-1:0]          req_ready;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IW-1:0]          rsp_id;
    logic [CW-1:0]          rsp_value;
    logic                   rsp_error;
    logic                   dp_reset_n;
    logic                   dp_a;
    logic                   dp_ready;
    logic                   dp_y;
    logic                   dp_valid;

    always #5 clk = ~clk;

    unary_root_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_value  (req_value),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_value  (rsp_value),
        .rsp_error  (rsp_error),
        .dp_reset_n (dp_reset_n),
        .dp_a       (dp_a),
        .dp_ready   (dp_ready),
        .dp_y       (dp_y),
        .dp_valid   (dp_valid)
    );

    typedef struct {
        int          id;
        int          value;
        int          tol;
        int          err;
        int          ones;
        int          len;
        bit          chk_pat;
        logic [31:0] pat;
    } exp_t;

    typedef struct {
        int          req;
        int          value;
        int          mode;
        int          exp_value;
        int          tol;
        int          exp_ones;
        bit          chk_pat;
        logic [31:0] pat;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   total = 0;
    int   bad   = 0;
    int   n_rsp = 0;
    int   dp_mode = M_ECHO;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_tol(input string name, input int act, input int exp, input int tol);
        total++;
        if ((act < exp - tol) || (act > exp + tol)) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    task automatic push_exp(input int id, input int value, input int tol, input int err,
                            input int ones, input bit chk_pat, input logic [31:0] pat);
        exp_t e;
        e.id = id; e.value = value; e.tol = tol; e.err = err;
        e.ones = ones; e.len = W; e.chk_pat = chk_pat; e.pat = pat;
        sb.push_back(e);
    endtask

    function automatic int isqrt(input int n);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    // ---------------- datapath model ----------------
    int   m_in, m_ones, m_emit, m_acc, m_k;
    logic m_valid, m_y;
    assign dp_valid = m_valid;
    assign dp_y     = m_y;

    always @(posedge clk) begin
        if (!dp_reset_n) begin
            m_in <= 0; m_ones <= 0; m_emit <= 0; m_acc <= 0; m_k <= 0;
            m_valid <= 1'b0; m_y <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            m_y     <= 1'b0;
            case (dp_mode)
                M_ECHO: begin
                    m_valid <= dp_ready;
                    m_y     <= dp_a & dp_ready;
                end
                M_SQRT: begin
                    if (dp_ready) begin
                        m_in   <= m_in + 1;
                        m_ones <= m_ones + int'(dp_a);
                        if (m_in == W - 1) begin
                            m_k    <= isqrt((m_ones + int'(dp_a)) * W);
                            m_emit <= W;
                            m_acc  <= 0;
                        end
                    end
                    if (m_emit > 0) begin
                        m_valid <= 1'b1;
                        m_emit  <= m_emit - 1;
                        if (m_acc + m_k >= W) begin
                            m_y   <= 1'b1;
                            m_acc <= m_acc + m_k - W;
                        end else begin
                            m_acc <= m_acc + m_k;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- response monitor / scoreboard ----------------
    int          s_ones, s_len;
    logic [63:0] s_pat;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            s_ones = 0; s_len = 0; s_pat = '0;
        end else begin
            if (dp_ready === 1'b1) begin
                if (s_len < 64) s_pat[s_len] = dp_a;
                s_ones += int'(dp_a);
                s_len++;
            end
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_empty: got response id %0d value %0d expected none", rsp_id, rsp_value);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk_tol("rsp_value", int'(rsp_value), e.value, e.tol);
                    chk("rsp_error", rsp_error, e.err);
                    chk("stream_ones", s_ones, e.ones);
                    chk("stream_len", s_len, e.len);
                    if (e.chk_pat) chk("stream_pattern", s_pat[31:0], e.pat);
                end
                n_rsp++;
                s_ones = 0; s_len = 0; s_pat = '0;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_grant(input int r);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (req_ready[r] === 1'b1) begin
                seen = 1'b1;
                chk("grant_onehot", req_ready, 4'b0001 << r);
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL grant_timeout: req %0d got no req_ready expected one within 400 cycles", r);
        end
    endtask

    // Drops the request after the accept edge and counts cycles to rsp_valid.
    task automatic run_to_rsp(input int r, output int lat);
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        @(negedge clk);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        if (rsp_valid !== 1'b1) begin
            total++; bad++;
            $display("FAIL rsp_timeout: got no rsp_valid expected one within 400 cycles");
        end
    endtask

    task automatic wait_rsp_count(input int n);
        int k;
        k = 0;
        while (n_rsp < n && k < 600) begin
            @(negedge clk);
            k++;
        end
        chk("rsp_count", n_rsp, n);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 4'b0000);
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, "_rsp_id"}, rsp_id, 2'd0);
        chk({tag, "_rsp_value"}, rsp_value, 6'd0);
        chk({tag, "_rsp_error"}, rsp_error, 1'b0);
        chk({tag, "_dp_reset_n"}, dp_reset_n, 1'b0);
        chk({tag, "_dp_a"}, dp_a, 1'b0);
        chk({tag, "_dp_ready"}, dp_ready, 1'b0);
    endtask

    initial begin
        int lat;
        int base;
        reset     = 1'b0;
        req_valid = '0;
        req_value = '0;
        rsp_ready = 1'b1;
        dp_mode   = M_ECHO;

        vecs[0] = '{0, 16, M_ECHO, 16, 0, 16, 1'b1, 32'hAAAA_AAAA, 35};
        vecs[1] = '{1,  0, M_ECHO,  0, 0,  0, 1'b1, 32'h0000_0000, 35};
        vecs[2] = '{2, 32, M_ECHO, 32, 0, 32, 1'b1, 32'hFFFF_FFFF, 35};
        vecs[3] = '{3, 40, M_ECHO, 32, 0, 32, 1'b1, 32'hFFFF_FFFF, 35};
        vecs[4] = '{0,  8, M_SQRT, 16, 2,  8, 1'b1, 32'h8888_8888, 0};
        vecs[5] = '{1,  5, M_ECHO,  5, 0,  5, 1'b0, 32'h0000_0000, 35};
        vecs[6] = '{2, 31, M_ECHO, 31, 0, 31, 1'b0, 32'h0000_0000, 35};
        vecs[7] = '{3,  1, M_ECHO,  1, 0,  1, 1'b0, 32'h0000_0000, 35};

        // Reset state and dp_reset_n release timing.
        #12;
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("dp_reset_n_before_clk", dp_reset_n, 1'b0);
        @(negedge clk);
        chk("dp_reset_n_after_clk", dp_reset_n, 1'b1);
        @(posedge clk); #1;

        // Arbitration: req0+req2 with pointer 0, then req1+req3 with pointer 3.
        dp_mode = M_ECHO;
        req_value[0] = 6'd3;  req_value[2] = 6'd7;
        push_exp(0, 3, 0, 0, 3, 1'b0, 32'h0);
        push_exp(2, 7, 0, 0, 7, 1'b0, 32'h0);
        req_valid[0] = 1'b1; req_valid[2] = 1'b1;
        wait_grant(0);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_grant(2);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        req_value[1] = 6'd9; req_value[3] = 6'd11;
        push_exp(3, 11, 0, 0, 11, 1'b0, 32'h0);
        push_exp(1, 9, 0, 0, 9, 1'b0, 32'h0);
        req_valid[1] = 1'b1; req_valid[3] = 1'b1;
        wait_grant(3);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        wait_grant(1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_rsp_count(4);

        // Table-driven single jobs.
        for (int i = 0; i < 8; i++) begin
            dp_mode = vecs[i].mode;
            push_exp(vecs[i].req, vecs[i].exp_value, vecs[i].tol, 0,
                     vecs[i].exp_ones, vecs[i].chk_pat, vecs[i].pat);
            req_value[vecs[i].req] = CW'(vecs[i].value);
            req_valid[vecs[i].req] = 1'b1;
            wait_grant(vecs[i].req);
            run_to_rsp(vecs[i].req, lat);
            if (vecs[i].lat != 0) chk("latency", lat, vecs[i].lat);
            @(posedge clk); #1;
        end

        // Response backpressure: outputs hold, no new accept.
        base = n_rsp;
        dp_mode = M_ECHO;
        rsp_ready = 1'b0;
        req_value[0] = 6'd12;
        push_exp(0, 12, 0, 0, 12, 1'b0, 32'h0);
        req_valid[0] = 1'b1;
        wait_grant(0);
        run_to_rsp(0, lat);
        @(posedge clk); #1;
        req_value[1] = 6'd4;
        req_valid[1] = 1'b1;
        push_exp(1, 4, 0, 0, 4, 1'b0, 32'h0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_rsp_valid", rsp_valid, 1'b1);
            chk("hold_rsp_id", rsp_id, 2'd0);
            chk("hold_rsp_value", rsp_value, 6'd12);
            chk("hold_no_req_ready", req_ready, 4'b0000);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_grant(1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_rsp_count(base + 2);

`ifdef UNARY_ROOT_SCHED_TIMEOUT_EN
        // Watchdog: datapath never answers.
        dp_mode = M_STUCK;
        req_value[1] = 6'd16;
        push_exp(1, 0, 0, 1, 16, 1'b0, 32'h0);
        req_valid[1] = 1'b1;
        wait_grant(1);
        run_to_rsp(1, lat);
        chk("timeout_latency", lat, 130);
        @(posedge clk); #1;
        @(negedge clk);
        chk("error_cleared", rsp_error, 1'b0);
        @(posedge clk); #1;
        dp_mode = M_ECHO;
`endif

        // Asynchronous reset in the middle of STREAM.
        dp_mode = M_ECHO;
        req_value[2] = 6'd16;
        req_valid[2] = 1'b1;
        wait_grant(2);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        repeat (6) @(negedge clk);
        chk("midjob_in_stream", dp_ready, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("midjob");
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("recover_dp_reset_n_low", dp_reset_n, 1'b0);
        @(negedge clk);
        chk("recover_dp_reset_n_high", dp_reset_n, 1'b1);
        @(posedge clk); #1;

        // Recovery job after reset.
        base = n_rsp;
        req_value[1] = 6'd16;
        push_exp(1, 16, 0, 0, 16, 1'b1, 32'hAAAA_AAAA);
        req_valid[1] = 1'b1;
        wait_grant(1);
        run_to_rsp(1, lat);
        chk("recover_latency", lat, 35);
        @(posedge clk); #1;
        wait_rsp_count(base + 1);

        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unary_root_scheduler.md
# unary_root_scheduler

Arbitrating job controller for one shared unary square-root datapath (`UnaryRootTwo`). It accepts binary "ones count" jobs from `NUM_REQ` requesters and picks one job at a time by round-robin. For each job it restarts the datapath, converts the value to an evenly spread unary bitstream and feeds it in. It then counts the datapath's output stream and returns the result ones-count, tagged with the requester ID.

## Interface
- `NUM_REQ`, default 4: number of requesters.
- `INPUT_WIDTH`, default 32: stream length in bits; must match the datapath.
- `COUNT_WIDTH`, default `$clog2(INPUT_WIDTH+1)`: ones-count width.
- `ID_WIDTH`, default `$clog2(NUM_REQ)` with a minimum of 1: requester ID width.
- `TIMEOUT_CYCLES`, default `4*INPUT_WIDTH`: watchdog limit. Used only when `UNARY_ROOT_SCHED_TIMEOUT_EN` is defined.
- `clk`, input, 1: clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, `[NUM_REQ]`: per-requester job request.
- `req_value`, input, `[NUM_REQ][COUNT_WIDTH]`: input ones-count, 0..`INPUT_WIDTH`.
- `req_ready`, output, `[NUM_REQ]`: one-hot accept strobe.
- `rsp_valid`, output, 1: result available.
- `rsp_ready`, input, 1: consumer accepts the result.
- `rsp_id`, output, `ID_WIDTH`: index of the requester that owns the result.
- `rsp_value`, output, `COUNT_WIDTH`: output ones-count.
- `rsp_error`, output, 1: watchdog abort flag.
- `dp_reset_n`, output, 1: registered active-low reset to the datapath.
- `dp_a`, output, 1: unary input bit.
- `dp_ready`, output, 1: input-bit strobe.
- `dp_y`, input, 1: datapath output bit.
- `dp_valid`, input, 1: datapath output-bit strobe.

## Operation
- The FSM has five states: IDLE, CLEAR, STREAM, DRAIN, RESP.
- IDLE
  - The arbiter grants the first asserted `req_valid` at or after the RR pointer.
  - `req_ready[g]` is combinational and asserted only in IDLE.
  - On accept the block:
    - captures `req_value`, saturating any value above `INPUT_WIDTH` to `INPUT_WIDTH`;
    - captures the ID;
    - moves the pointer to g+1 mod `NUM_REQ`;
    - goes to CLEAR.
- CLEAR (one cycle)
  - `dp_reset_n` = 0.
  - Accumulator `acc` = 0, `in_cnt` = 0, `out_cnt` = 0, `ones` = 0.
  - Next state is STREAM.
- STREAM
  - `dp_ready` = 1.
  - Each cycle: `sum` = `acc` + value. If `sum` ≥ `INPUT_WIDTH`, then `dp_a` = 1 and `acc` = `sum` − `INPUT_WIDTH`; otherwise `dp_a` = 0 and `acc` = `sum`.
  - `acc` is `COUNT_WIDTH`+1 bits wide.
  - The block exits to DRAIN after `in_cnt` reaches `INPUT_WIDTH` cycles.
  - Exactly `value` ones are emitted.
- DRAIN
  - `dp_ready` = 0 and `dp_a` = 0.
  - The block waits for `out_cnt` = `INPUT_WIDTH`.
- Output collection
  - Active in STREAM and DRAIN. Ignored in IDLE, CLEAR and RESP.
  - Each cycle with `dp_valid` = 1: `out_cnt`++ and `ones` += `dp_y`.
  - When `out_cnt` reaches `INPUT_WIDTH` the block goes to RESP, from either STREAM or DRAIN.
  - Leaving STREAM early this way still stops `dp_ready`.
- RESP
  - `rsp_valid` = 1, `rsp_value` = `ones`, `rsp_id` = captured ID.
  - All three are held stable until `rsp_ready`, then the block returns to IDLE.
  - `rsp_value` counts up to `INPUT_WIDTH` and never wraps.
- Simultaneous requests: only the granted requester sees `req_ready`. The others stay pending, and requests are never dropped.
- `req_valid` deasserting in non-IDLE states has no effect.

## Timing
- Reset values of outputs:
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_value` = 0, `rsp_error` = 0;
  - `dp_reset_n` = 0, `dp_a` = 0, `dp_ready` = 0.
- Reset values of internal state: state = IDLE, RR pointer = 0.
- `dp_reset_n` goes to 1 on the first clock after reset release.
- Accept at cycle t:
  - t+1 is CLEAR.
  - t+2 .. t+1+`INPUT_WIDTH` is STREAM.
  - The earliest `rsp_valid` is one cycle after the final counted `dp_valid`.
- Back-to-back jobs: the cycle after `rsp_ready` is IDLE, so the minimum accept-to-accept spacing is `INPUT_WIDTH`+4 cycles.
- Reset mid-job: asynchronous. All outputs go to their reset values immediately and `dp_reset_n` is asserted. The in-flight job is lost.

## Configuration
- `UNARY_ROOT_SCHED_TIMEOUT_EN` defined:
  - A watchdog counts cycles spent in STREAM+DRAIN.
  - When it reaches `TIMEOUT_CYCLES`, the block enters RESP with `rsp_error` = 1 and `rsp_value` = ones collected so far.
  - `rsp_error` is cleared on leaving RESP.
- Not defined: there is no watchdog, `rsp_error` is tied to 0, and DRAIN waits indefinitely.

## Structure
- Package `unary_root_sched_pkg` holds:
  - the state enum `sched_state_e` (IDLE, CLEAR, STREAM, DRAIN, RESP);
  - the default `INPUT_WIDTH`;
  - the `TIMEOUT_CYCLES` default multiplier.
- Sub-module `rr_arbiter` (parameter `NUM_REQ`): inputs are `req`, `ptr` and `en`; outputs are the one-hot `gnt` and the binary `gnt_id`. It is purely combinational.
- The pointer register stays in the parent.

## Test plan
- `INPUT_WIDTH`=32, req0 value 16: the `dp_a` stream during STREAM is 0101…, with exactly 16 ones over 32 cycles. `rsp_id` = 0.
- Value 0 → `rsp_value` = 0. Value 32 → all-ones input and `rsp_value` = 32. Value 40 is saturated to 32.
- Value 8 (0.25) with the real datapath → `rsp_value` = 16 ±2 and `rsp_error` = 0.
- req0 and req2 valid together with pointer 0 → req0 served first, then req2. The pointer then goes to 3, so a req1 raised later is served after req2.
- `rsp_ready` held low for 10 cycles → `rsp_valid`, `rsp_id` and `rsp_value` stay stable and no new `req_ready` is asserted.
- With the TIMEOUT macro, `dp_valid` stuck at 0 → `rsp_valid` with `rsp_error` = 1 and `rsp_value` = 0 after 128 cycles. Reset asserted mid-STREAM → all outputs at reset values, and `dp_reset_n` = 0 immediately.
